// File: rtl/visit_count_updater.sv
// Read-modify-write controller in front of a single-port BRAM of visit counters.
// Zero-fills on reset or request, increments counters, and serves single-word readout.
module visit_count_updater #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8192
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start_clear,
    output logic                  o_clear_done,
    input  logic                  i_node_valid,
    input  logic [ADDR_WIDTH-1:0] i_node_id,
    output logic                  o_node_ready,
    input  logic                  i_rd_req,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rd_ready,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_sat,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_write,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic [DATA_WIDTH-1:0] i_mem_data
);

    typedef enum logic [2:0] {
        CLEAR, IDLE, INC_RD, INC_WAIT, INC_WR, RD_ADDR, RD_WAIT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES  = '1;

    state_t                state;
    logic [DATA_WIDTH-1:0] bumped;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
        return (v == ALL_ONES) ? v : v + DATA_WIDTH'(1);
    endfunction

    assign bumped = sat_inc(i_mem_data);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= CLEAR;
            o_mem_addr   <= '0;
            o_mem_write  <= 1'b1;
            o_mem_data   <= '0;
            o_node_ready <= 1'b0;
            o_rd_ready   <= 1'b0;
            o_rd_valid   <= 1'b0;
            o_rd_data    <= '0;
            o_clear_done <= 1'b0;
            o_sat        <= 1'b0;
        end else begin
            o_clear_done <= 1'b0;
            o_rd_valid   <= 1'b0;
            case (state)
                // o_mem_addr doubles as the zero-fill counter
                CLEAR: begin
                    if (o_mem_addr == LAST_ADDR) begin
                        o_mem_write  <= 1'b0;
                        o_clear_done <= 1'b1;
                        o_node_ready <= 1'b1;
                        o_rd_ready   <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        o_mem_addr <= o_mem_addr + 1'b1;
                    end
                end
                IDLE: begin
                    if (i_start_clear) begin
                        o_mem_addr   <= '0;
                        o_mem_write  <= 1'b1;
                        o_mem_data   <= '0;
                        o_sat        <= 1'b0;
                        o_node_ready <= 1'b0;
                        o_rd_ready   <= 1'b0;
                        state        <= CLEAR;
                    end else if (i_node_valid) begin
                        o_mem_addr   <= i_node_id;
                        o_mem_write  <= 1'b0;
                        o_node_ready <= 1'b0;
                        o_rd_ready   <= 1'b0;
                        state        <= INC_RD;
                    end else if (i_rd_req) begin
                        o_mem_addr   <= i_rd_addr;
                        o_mem_write  <= 1'b0;
                        o_node_ready <= 1'b0;
                        o_rd_ready   <= 1'b0;
                        state        <= RD_ADDR;
                    end
                end
                INC_RD: state <= INC_WAIT;
                INC_WAIT: begin
                    o_mem_data  <= bumped;
                    o_mem_write <= 1'b1;
                    if (bumped == ALL_ONES) begin
                        o_sat <= 1'b1;
                    end
                    state <= INC_WR;
                end
                INC_WR: begin
                    o_mem_write  <= 1'b0;
                    o_node_ready <= 1'b1;
                    o_rd_ready   <= 1'b1;
                    state        <= IDLE;
                end
                RD_ADDR: state <= RD_WAIT;
                RD_WAIT: begin
                    o_rd_data    <= i_mem_data;
                    o_rd_valid   <= 1'b1;
                    o_node_ready <= 1'b1;
                    o_rd_ready   <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    o_mem_write  <= 1'b0;
                    o_node_ready <= 1'b1;
                    o_rd_ready   <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_visit_count_updater.sv
// Bench for visit_count_updater: BRAM model, vector table, random ops against an array model,
// and hand sequences for saturation, clear priority and reset during an increment.
module tb_visit_count_updater;

    localparam int DEPTH = 8192;

    logic        clk;
    logic        rst_n;
    logic        start_clear;
    logic        clear_done;
    logic        node_valid;
    logic [12:0] node_id;
    logic        node_ready;
    logic        rd_req;
    logic [12:0] rd_addr;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        sat;
    logic [12:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        preload_en;
    logic [12:0] preload_addr;
    logic [31:0] preload_data;
    logic [31:0] mem [0:DEPTH-1];

    logic [31:0] model [0:DEPTH-1];
    logic        model_sat;

    int checks;
    int errors;

    visit_count_updater #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_start_clear(start_clear), .o_clear_done(clear_done),
        .i_node_valid(node_valid), .i_node_id(node_id), .o_node_ready(node_ready),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ready(rd_ready),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_sat(sat),
        .o_mem_addr(mem_addr), .o_mem_write(mem_write), .o_mem_data(mem_wdata),
        .i_mem_data(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM, read-first, one cycle read latency
    always @(posedge clk) begin
        if (preload_en) mem[preload_addr] <= preload_data;
        else if (mem_write) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [12:0] a);
        longint v;
        v = longint'(model[a]) + 1;
        if (v > 64'hFFFF_FFFF) v = 64'hFFFF_FFFF;
        return v[31:0];
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctrl"}, 32'({mem_write, node_ready, rd_ready, rd_valid, clear_done, sat}), 32'h20);
        chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_rdata"}, rd_data, 32'h0);
    endtask

    // Entered anywhere in the first zero-fill cycle, before its falling edge
    task automatic wait_clear();
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (!mem_write || mem_addr != 13'(i) || mem_wdata != 32'h0 ||
                node_ready || rd_ready || clear_done) bad++;
        end
        chk("clear_sweep_bad_cycles", 32'(bad), 32'h0);
        @(negedge clk);
        chk("clear_done_pulse", 32'(clear_done), 32'h1);
        chk("ready_after_clear", 32'(node_ready && rd_ready), 32'h1);
        chk("clear_write_off", 32'(mem_write), 32'h0);
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic do_inc(input logic [12:0] id, input logic [31:0] exp);
        int  n;
        logic ok;
        node_valid = 1'b1;
        node_id    = id;
        n = 0;
        while (!node_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("inc_accept", 32'(node_ready), 32'h1);
        if (!node_ready) begin
            node_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 node_valid = 1'b0;
        ok = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (node_ready || rd_ready) ok = 1'b0;
            if (k < 3 && mem_write) ok = 1'b0;
            if (k == 3) begin
                chk("inc_wr_en", 32'(mem_write), 32'h1);
                chk("inc_wr_addr", 32'(mem_addr), 32'(id));
                chk("inc_wr_data", mem_wdata, exp);
            end
        end
        chk("inc_busy_window", 32'(ok), 32'h1);
        model[id] = model_next(id);
        if (model[id] == 32'hFFFF_FFFF) model_sat = 1'b1;
        @(negedge clk);
        chk("inc_ready_again", 32'(node_ready && rd_ready), 32'h1);
        chk("inc_wr_dropped", 32'(mem_write), 32'h0);
        chk("sat_flag", 32'(sat), 32'(model_sat));
    endtask

    task automatic do_read(input logic [12:0] a, input logic [31:0] exp);
        int  n;
        logic ok;
        rd_req  = 1'b1;
        rd_addr = a;
        n = 0;
        while (!rd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rd_accept", 32'(rd_ready), 32'h1);
        if (!rd_ready) begin
            rd_req = 1'b0;
            return;
        end
        @(posedge clk);
        #1 rd_req = 1'b0;
        ok = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            if (rd_valid || rd_ready || node_ready || mem_write) ok = 1'b0;
        end
        chk("rd_busy_window", 32'(ok), 32'h1);
        @(negedge clk);
        chk("rd_valid", 32'(rd_valid), 32'h1);
        chk("rd_data", rd_data, exp);
        chk("rd_ready_again", 32'(rd_ready), 32'h1);
        @(negedge clk);
        chk("rd_valid_pulse", 32'(rd_valid), 32'h0);
        chk("rd_data_hold", rd_data, exp);
    endtask

    typedef struct {
        logic        rd;
        logic [12:0] addr;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [10];
    logic [12:0] pool [6];

    initial begin
        checks = 0;
        errors = 0;
        model_sat = 1'b0;
        rst_n = 1'b0;
        start_clear = 1'b0;
        node_valid = 1'b0;
        node_id = 13'd0;
        rd_req = 1'b0;
        rd_addr = 13'd0;
        preload_en = 1'b0;
        preload_addr = 13'd0;
        preload_data = 32'h0;

        vecs[0] = '{1'b0, 13'd5,    32'd1};
        vecs[1] = '{1'b0, 13'd5,    32'd2};
        vecs[2] = '{1'b0, 13'd5,    32'd3};
        vecs[3] = '{1'b1, 13'd5,    32'd3};
        vecs[4] = '{1'b0, 13'd0,    32'd1};
        vecs[5] = '{1'b0, 13'd8191, 32'd1};
        vecs[6] = '{1'b0, 13'd0,    32'd2};
        vecs[7] = '{1'b1, 13'd0,    32'd2};
        vecs[8] = '{1'b1, 13'd8191, 32'd1};
        vecs[9] = '{1'b1, 13'd100,  32'd0};
        pool[0] = 13'd0;
        pool[1] = 13'd1;
        pool[2] = 13'd5;
        pool[3] = 13'd7;
        pool[4] = 13'd8190;
        pool[5] = 13'd8191;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_clear();

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].rd) do_read(vecs[v].addr, vecs[v].exp);
            else do_inc(vecs[v].addr, vecs[v].exp);
        end

        for (int r = 0; r < 40; r++) begin
            logic [12:0] a;
            a = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 0) do_inc(a, model_next(a));
            else do_read(a, model[a]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Saturation, then a requested zero-fill clears the sticky flag
        preload_en = 1'b1;
        preload_addr = 13'd7;
        preload_data = 32'hFFFF_FFFE;
        @(posedge clk);
        #1 preload_en = 1'b0;
        model[7] = 32'hFFFF_FFFE;
        do_inc(13'd7, 32'hFFFF_FFFF);
        do_inc(13'd7, 32'hFFFF_FFFF);
        do_read(13'd7, 32'hFFFF_FFFF);
        chk("sat_after_saturation", 32'(sat), 32'h1);
        start_clear = 1'b1;
        @(posedge clk);
        #1 start_clear = 1'b0;
        model_sat = 1'b0;
        chk("sat_cleared_by_start", 32'(sat), 32'h0);
        wait_clear();
        do_read(13'd7, 32'h0);

        // Clear, increment and read all requested together: clear wins
        @(negedge clk);
        start_clear = 1'b1;
        node_valid = 1'b1;
        node_id = 13'd9;
        rd_req = 1'b1;
        rd_addr = 13'd9;
        chk("prio_idle_ready", 32'(node_ready && rd_ready), 32'h1);
        @(posedge clk);
        #1 start_clear = 1'b0;
        rd_req = 1'b0;
        chk("prio_clear_wins", 32'({mem_write, mem_addr}), 32'h2000);
        wait_clear();
        do_inc(13'd9, model_next(13'd9));
        do_read(13'd9, 32'd1);

        // Reset asserted while the increment of node 12 waits for read data
        node_valid = 1'b1;
        node_id = 13'd12;
        for (int n = 0; n < 100 && !node_ready; n++) @(negedge clk);
        chk("rst_inc_accept", 32'(node_ready), 32'h1);
        @(posedge clk);
        #1 node_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("midinc_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_sat = 1'b0;
        wait_clear();
        do_read(13'd12, 32'h0);
        chk("sat_after_reset", 32'(sat), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
